// File: rtl/shift_iter_nbit.sv
// Iterative barrel shifter: one shift stage per clock, with a valid/ready
// handshake on both the request side and the result side.
// Stage k shifts by 2^k when bit k of the captured shift amount is set.
// The latency is always SHIFT_WIDTH cycles, whatever the shift amount.
module shift_iter_nbit #(
    parameter int WIDTH       = 8,
    parameter int SHIFT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       A,
    input  logic [SHIFT_WIDTH-1:0] B,
    input  logic [1:0]             mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       Y
);

    localparam int CNT_W = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1;
    localparam int LOG_W = $clog2(WIDTH);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [SHIFT_WIDTH-1:0] b_r;
    logic [1:0]             mode_r;
    logic                   sign_r;
    logic [WIDTH-1:0]       work_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [WIDTH-1:0]       stage_val_s;

    // Shift v by 2^stage in the given mode. Stages whose distance reaches
    // WIDTH saturate: zeros for logical shifts, sign bits for ASR, and a
    // full rotation (no change) for ROL.
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] v,
        input int unsigned      stage,
        input logic [1:0]       m,
        input logic             sign
    );
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] r;
        int unsigned      sh;
        fill = {WIDTH{sign}};
        r    = v;
        sh   = 32'd0;
        if (stage >= LOG_W) begin
            case (m)
                MODE_LSL: r = '0;
                MODE_LSR: r = '0;
                MODE_ASR: r = fill;
                MODE_ROL: r = v;
                default:  r = v;
            endcase
        end else begin
            sh = 32'd1 << stage;
            case (m)
                MODE_LSL: r = v << sh;
                MODE_LSR: r = v >> sh;
                MODE_ASR: r = (v >> sh) | (fill & ~({WIDTH{1'b1}} >> sh));
                MODE_ROL: r = (v << sh) | (v >> (WIDTH - sh));
                default:  r = v;
            endcase
        end
        return r;
    endfunction

    // Candidate value of the working register after the current stage.
    always_comb begin
        stage_val_s = work_r;
        if (b_r[cnt_r]) begin
            stage_val_s = stage_shift(work_r, 32'(cnt_r), mode_r, sign_r);
        end else begin
            stage_val_s = work_r;
        end
    end

    // Control FSM together with the datapath registers and the registered
    // handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            b_r         <= '0;
            mode_r      <= 2'b00;
            sign_r      <= 1'b0;
            work_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        work_r      <= A;
                        b_r         <= B;
                        mode_r      <= mode;
                        sign_r      <= A[WIDTH-1];
                        cnt_r       <= '0;
                        state_r     <= BUSY;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b0;
                    end else begin
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                BUSY: begin
                    work_r <= stage_val_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r       <= '0;
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign Y         = work_r;

endmodule

// File: tb/tb_shift_iter_nbit.sv
// Scoreboard bench for shift_iter_nbit (WIDTH=8, SHIFT_WIDTH=3).
// The stimulus side pushes expected results when a request is accepted;
// a monitor pops and compares whenever a result handshake takes place.
module tb_shift_iter_nbit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [2:0] B;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Y;

    logic [7:0] exp_q[$];
    int         errors    = 0;
    int         checks    = 0;
    int         accepted  = 0;
    int         delivered = 0;
    logic       rand_rdy  = 1'b0;

    shift_iter_nbit #(.WIDTH(8), .SHIFT_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .Y(Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] a, input int b, input logic [1:0] m);
        logic signed [7:0] s;
        s = a;
        case (m)
            2'b00: return a << b;
            2'b01: return a >> b;
            2'b10: return s >>> b;
            2'b11: return (b == 0) ? a : ((a << b) | (a >> (8 - b)));
            default: return a;
        endcase
    endfunction

    // Result monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            delivered++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%0h expected none", Y);
            end else begin
                check("result", {24'd0, Y}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Random consumer stalls during the stream phase.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [2:0] b, input logic [1:0] m,
                        input logic [7:0] exp);
        int n;
        n = 0;
        in_valid = 1'b1; A = a; B = b; mode = m;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            exp_q.push_back(exp);
            accepted++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [7:0] ra;
        logic [2:0] rb;
        logic [1:0] rm;

        rst = 1'b1; in_valid = 1'b0; A = 8'h00; B = 3'd0; mode = 2'b00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_Y", {24'd0, Y}, 32'd0);
        @(posedge clk); #1;

        // Latency check on LSL 0x81 by 3.
        send(8'h81, 3'd3, 2'b00, 8'h08);
        lat = -1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'd3);
        @(negedge clk);
        check("back_to_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("back_to_idle_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Directed modes, then B=0 in every mode.
        send(8'h90, 3'd2, 2'b10, 8'hE4);
        send(8'h80, 3'd7, 2'b01, 8'h01);
        send(8'h81, 3'd1, 2'b11, 8'h03);
        send(8'h5A, 3'd0, 2'b00, 8'h5A);
        send(8'h5A, 3'd0, 2'b01, 8'h5A);
        send(8'h5A, 3'd0, 2'b10, 8'h5A);
        send(8'h5A, 3'd0, 2'b11, 8'h5A);
        send(8'h6D, 3'd5, 2'b10, 8'h03);
        send(8'hB3, 3'd4, 2'b11, 8'h3B);
        drain();

        // Consumer stall in DONE with input activity.
        out_ready = 1'b0;
        send(8'h3C, 3'd1, 2'b00, 8'h78);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = ~in_valid; A = 8'hC0 + 8'(k); B = 3'(k); mode = 2'(k);
            @(negedge clk);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_Y", {24'd0, Y}, 32'h78);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        send(8'h01, 3'd6, 2'b00, 8'h40);
        drain();

        // Reset while busy at cnt=1: the result must be discarded.
        send(8'h11, 3'd3, 2'b00, 8'h88);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        accepted--;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_Y", {24'd0, Y}, 32'd0);
        repeat (8) @(posedge clk);
        #1;

        // Randomized back-to-back stream against the reference model.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 3'($urandom_range(0, 7));
            rm = 2'($urandom_range(0, 3));
            send(ra, rb, rm, ref_shift(ra, int'(rb), rm));
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();
        repeat (4) @(posedge clk);
        #1;
        check("delivered_count", 32'(delivered), 32'(accepted));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_iter_nbit.md
SHIFT_ITER_NBIT -- requirements
Module: shift_iter_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits; legal values are powers of two, 2 or greater.
REQ-002 SHALL have parameter SHIFT_WIDTH, default 3, shift-amount width in bits; legal values are 1 or greater.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port A  input  WIDTH  operand.
REQ-008 SHALL have port B  input  SHIFT_WIDTH  unsigned shift amount.
REQ-009 SHALL have port mode  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port Y  output  WIDTH  result.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE.
REQ-015 SHALL drive out_valid=1 only in DONE.
REQ-016 SHALL, in IDLE when in_valid=1, capture A, B and mode into internal registers, clear stage counter cnt to 0, and move to BUSY.
REQ-017 SHALL, in each BUSY cycle, shift the working register by 2^cnt when captured B[cnt]=1 and leave it unchanged otherwise, then increment cnt.
REQ-018 SHALL move from BUSY to DONE on the edge that processes stage cnt=SHIFT_WIDTH-1.
REQ-019 SHALL therefore raise out_valid exactly SHIFT_WIDTH edges after the accepting edge, for every B, including B=0.
REQ-020 SHALL apply per-stage fill rules: LSL fills with 0 from the LSB; LSR fills with 0 from the MSB; ASR fills with the captured A[WIDTH-1]; ROL wraps bits from the MSB into the LSB.
REQ-021 SHALL, when a stage shift of 2^cnt is at least WIDTH, produce all zeros for LSL and LSR, all sign bits for ASR, and an unchanged value for ROL (rotation taken modulo WIDTH).
REQ-022 SHALL, in DONE, hold Y and out_valid stable while out_ready=0.
REQ-023 SHALL, in DONE when out_ready=1, return to IDLE on that edge; no new request is accepted on that same edge.
REQ-024 SHALL ignore in_valid, A, B and mode outside IDLE; captured values are not disturbed mid-operation.
REQ-025 SHALL drive Y from the working register in all states; its value is defined only while out_valid=1.
REQ-026 SHALL sustain one result per SHIFT_WIDTH+2 cycles under continuous valid and ready.

Reset
REQ-027 SHALL, while rst=1 at a rising edge, force state to IDLE, cnt to 0, and the working and captured registers to 0.
REQ-028 SHALL, after reset, drive out_valid=0, in_ready=1 and Y=0.
REQ-029 SHALL give rst priority over every other input, including rst asserted during BUSY or DONE; any in-flight result is discarded and never presented.
REQ-030 SHALL accept a request on the first edge after rst deasserts if in_valid=1.

Verification (WIDTH=8, SHIFT_WIDTH=3)
REQ-031 SHALL be verified with: A=0x81, B=3, mode=LSL, out_ready=1 -> out_valid rises 3 edges after accept, Y=0x08, then returns to IDLE.
REQ-032 SHALL be verified with: A=0x90, B=2, mode=ASR -> Y=0xE4; A=0x80, B=7, mode=LSR -> Y=0x01; A=0x81, B=1, mode=ROL -> Y=0x03.
REQ-033 SHALL be verified with: B=0 in each mode with A=0x5A -> Y=0x5A after the full 3-cycle latency.
REQ-034 SHALL be verified with: out_ready held 0 for 5 cycles in DONE, and in_valid toggled with new A/B during those cycles -> Y and out_valid stable and in_ready=0; release gives one handshake and the next request starts afterwards.
REQ-035 SHALL be verified with: rst pulsed for 1 cycle during BUSY (cnt=1) -> next cycle out_valid=0, in_ready=1, Y=0, and no stale result appears.
REQ-036 SHALL be verified with: a randomized back-to-back stream of 1000 requests with random out_ready stalls, checked against a reference model -> all results match and none are lost or duplicated.
